// File: rtl/audio_pkg.sv
// audio_pkg: shared sample type and output-stage state encoding for the audio path
package audio_pkg;
  localparam int SAMPLE_W = 24;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef enum logic [1:0] {OUT_EMPTY, OUT_FETCH, OUT_VALID} out_state_t;
endpackage

// File: rtl/sample_sdp_ram.sv
// sample_sdp_ram: simple dual-port RAM with registered read, no array reset so it maps to block RAM
module sample_sdp_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/sample_ring_buffer.sv
// sample_ring_buffer: circular PCM sample buffer with FWFT ready/valid read side, fill level and sticky overflow
module sample_ring_buffer
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH = 1024,
  parameter int READY_THRESHOLD = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic signed [DATA_W-1:0]   wr_data_i,
  input  logic                       wr_valid_i,
  output logic signed [DATA_W-1:0]   rd_data_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic                       buffer_ready_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH+2)-1:0] fill_level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int FW = $clog2(DEPTH+2);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  out_state_t state, state_next;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [FW-1:0] fill_next;
  logic [DATA_W-1:0] ram_q;
  logic wr_acc, rd_iss;
  sample_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr),
    .wdata_i (wr_data_i),
    .re_i    (rd_iss),
    .raddr_i (rd_ptr),
    .rdata_o (ram_q)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= OUT_EMPTY;
    else state <= state_next;
  always_comb
    state_next = flush_i ? OUT_EMPTY :
                 rd_iss ? OUT_FETCH :
                 state == OUT_FETCH ? OUT_VALID :
                 (state == OUT_VALID && rd_ready_i) ? OUT_EMPTY : state;
  always_comb begin
    rd_valid_o = state == OUT_VALID;
    rd_iss = !flush_i && count != '0 && (state == OUT_EMPTY || (rd_valid_o && rd_ready_i));
    fill_level_o = FW'(count) + FW'(state != OUT_EMPTY);
  end
  always_comb begin
    wr_acc = wr_valid_i && count != FULL && !flush_i;
    count_next = flush_i ? '0 : count + CW'(wr_acc) - CW'(rd_iss);
    fill_next = FW'(count_next) + FW'(state_next != OUT_EMPTY);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow_o <= 1'b0;
      buffer_ready_o <= 1'b0;
      rd_data_o <= '0;
    end else begin
      wr_ptr <= flush_i ? '0 : wr_ptr + AW'(wr_acc);
      rd_ptr <= flush_i ? '0 : rd_ptr + AW'(rd_iss);
      count <= count_next;
      overflow_o <= !flush_i && (overflow_o || (wr_valid_i && count == FULL));
      buffer_ready_o <= fill_next >= FW'(READY_THRESHOLD);
      if (state == OUT_FETCH) rd_data_o <= ram_q;
    end
endmodule

// File: tb/tb_sample_ring_buffer.sv
// tb_sample_ring_buffer: directed self-checking bench for sample_ring_buffer with DEPTH=8, READY_THRESHOLD=4
module tb_sample_ring_buffer;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [23:0] wr_data = '0, rd_data;
  logic rd_valid, buffer_ready, overflow;
  logic [3:0] fill;
  int checks = 0, errors = 0;
  int n_wr, n_rd, cyc;
  logic [23:0] q [$];
  always #5 clk = ~clk;
  sample_ring_buffer #(.DATA_W(24), .DEPTH(8), .READY_THRESHOLD(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .wr_data_i      (wr_data),
    .wr_valid_i     (wr_valid),
    .rd_data_o      (rd_data),
    .rd_valid_o     (rd_valid),
    .rd_ready_i     (rd_ready),
    .buffer_ready_o (buffer_ready),
    .overflow_o     (overflow),
    .fill_level_o   (fill)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(input logic [23:0] d);
    wr_valid = 1'b1;
    wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_bready"}, buffer_ready, 0);
    chk({tag, "_fill"}, fill, 0);
  endtask
  initial begin
    #3 all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    step();
    wr(24'h800001);
    chk("single_fill_n1", fill, 1);
    chk("single_valid_n1", rd_valid, 0);
    step();
    chk("single_valid_n2a", rd_valid, 0);
    step();
    chk("single_valid_n2", rd_valid, 1);
    chk("single_data", rd_data, 24'h800001);
    chk("single_fill_n2", fill, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("single_valid_after", rd_valid, 0);
    chk("single_fill_after", fill, 0);
    for (int k = 1; k <= 9; k++) begin
      wr(24'(k));
      chk("bp_fill", fill, k);
      chk("bp_bready", buffer_ready, k >= 4);
      chk("bp_ovf", overflow, 0);
      if (k >= 3) chk("bp_head", rd_data, 1);
    end
    wr(24'd10);
    chk("bp_ovf_set", overflow, 1);
    chk("bp_fill_full", fill, 9);
    chk("bp_head_hold", rd_data, 1);
    chk("bp_valid_hold", rd_valid, 1);
    rd_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i);
      chk("drain_fill", fill, 10 - i);
      step();
      chk("drain_gap", rd_valid, 0);
      chk("drain_fill_hs", fill, 9 - i);
      chk("drain_bready_hs", buffer_ready, (9 - i) >= 4);
      step();
    end
    chk("drain_no_extra", rd_valid, 0);
    chk("drain_empty", fill, 0);
    chk("drain_ovf_sticky", overflow, 1);
    rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) wr(24'h200 + 24'(k));
    chk("flush_pre_fill", fill, 5);
    chk("flush_pre_ovf", overflow, 1);
    flush = 1'b1;
    wr(24'h000123);
    flush = 1'b0;
    chk("flush_fill", fill, 0);
    chk("flush_valid", rd_valid, 0);
    chk("flush_ovf", overflow, 0);
    chk("flush_bready", buffer_ready, 0);
    step();
    chk("flush_ignored_wr", fill, 0);
    wr(24'hABCDEF);
    step();
    chk("flush_rb_wait", rd_valid, 0);
    step();
    chk("flush_rb_valid", rd_valid, 1);
    chk("flush_rb_data", rd_data, 24'hABCDEF);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("flush_rb_empty", fill, 0);
    n_wr = 0;
    n_rd = 0;
    cyc = 0;
    while (n_rd < 40 && cyc < 2000) begin
      rd_ready = ($urandom_range(3, 0) != 0);
      wr_valid = n_wr < 40 && cyc % 3 == 0 && fill < 4'd8;
      if (wr_valid) begin
        wr_data = 24'(32'h100000 + n_wr * 311);
        q.push_back(wr_data);
        n_wr++;
      end
      if (rd_valid && rd_ready) begin
        chk("wrap_data", rd_data, q.pop_front());
        n_rd++;
      end
      step();
      cyc++;
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    chk("wrap_count", n_rd, 40);
    chk("wrap_ovf", overflow, 0);
    for (int k = 0; k < 3; k++) wr(24'h300 + 24'(k));
    chk("ar_pre_fill3", fill, 3);
    rd_ready = 1'b1;
    wr(24'h000303);
    rd_ready = 1'b0;
    chk("ar_fetch_fill", fill, 3);
    chk("ar_fetch_valid", rd_valid, 0);
    #2 rst_n = 1'b0;
    #1 all_zero("async");
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("ar_no_stale_valid", rd_valid, 0);
    chk("ar_no_stale_fill", fill, 0);
    wr(24'h55AA55);
    chk("ar_wr_fill", fill, 1);
    step();
    chk("ar_wr_wait", rd_valid, 0);
    step();
    chk("ar_wr_valid", rd_valid, 1);
    chk("ar_wr_data", rd_data, 24'h55AA55);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
